// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access op codes, FSM state
// encoding and the alignment predicate.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } ls_op_t;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } lsu_state_t;

  // Word ops need a 4-byte boundary, halfword ops a 2-byte boundary.
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
    logic m;
    m = 1'b0;
    case (op)
      OP_LW, OP_SW:         m = (addr_lo != 2'b00);
      OP_LH, OP_LHU, OP_SH: m = addr_lo[0];
      default:              m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic is_subword_store(input logic [2:0] op);
    logic s;
    s = 1'b0;
    case (op)
      OP_SB, OP_SH: s = 1'b1;
      default:      s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ls_byte_lane.sv
// Big-endian lane logic: extracts and extends load results from a memory
// word, and builds the merged word for sub-word stores.
module ls_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte 0 sits in the most significant lane.
  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo)
      2'd0:    byte_sel = word[31:24];
      2'd1:    byte_sel = word[23:16];
      2'd2:    byte_sel = word[15:8];
      2'd3:    byte_sel = word[7:0];
      default: byte_sel = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_sel = word[15:0];
    end else begin
      half_sel = word[31:16];
    end
  end

  // Load extension.
  always_comb begin
    load_data = 32'h0000_0000;
    case (op)
      OP_LW:   load_data = word;
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'h0000, half_sel};
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'h00_0000, byte_sel};
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Store merge: replace only the addressed lane of the fetched word.
  always_comb begin
    merge_data = word;
    case (op)
      OP_SB: begin
        case (addr_lo)
          2'd0:    merge_data[31:24] = wdata[7:0];
          2'd1:    merge_data[23:16] = wdata[7:0];
          2'd2:    merge_data[15:8]  = wdata[7:0];
          2'd3:    merge_data[7:0]   = wdata[7:0];
          default: merge_data = word;
        endcase
      end
      OP_SH: begin
        if (addr_lo[1]) begin
          merge_data[15:0] = wdata[15:0];
        end else begin
          merge_data[31:16] = wdata[15:0];
        end
      end
      default: merge_data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-only data memory: sub-word loads,
// read-modify-write sub-word stores and sticky misalignment reporting.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ls_req,
  input  logic [2:0]    ls_op,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic [DW-1:0] ls_rdata,
  output logic          ls_stall,
  output logic          ls_misalign,
  output logic          ls_fault,
  output logic [AW-1:0] fault_addr,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] write_data,
  output logic          MemRead,
  output logic          MemWrite,
  input  logic [DW-1:0] read_data
);

  lsu_state_t    state;
  lsu_state_t    state_next;
  logic [DW-1:0] merge_word;
  logic [AW-1:0] merge_index;
  logic [AW-1:0] word_index;
  logic          misalign_now;
  logic          start_rmw;
  logic [DW-1:0] lane_load;
  logic [DW-1:0] lane_merge;

  assign word_index   = {2'b00, ls_addr[AW-1:2]};
  assign misalign_now = (state == IDLE) && ls_req && misaligned(ls_op, ls_addr[1:0]);
  assign start_rmw    = (state == IDLE) && ls_req && !misalign_now && is_subword_store(ls_op);
  assign ls_misalign  = misalign_now;

  ls_byte_lane u_lane (
    .op         (ls_op),
    .addr_lo    (ls_addr[1:0]),
    .word       (read_data),
    .wdata      (ls_wdata),
    .load_data  (lane_load),
    .merge_data (lane_merge)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture of the merged word and its index for the write-back cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      merge_word  <= '0;
      merge_index <= '0;
    end else if (start_rmw) begin
      merge_word  <= lane_merge;
      merge_index <= word_index;
    end else begin
      merge_word  <= merge_word;
      merge_index <= merge_index;
    end
  end

  // Sticky fault flag; only the first misaligned address is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls_fault   <= 1'b0;
      fault_addr <= '0;
    end else if (misalign_now && !ls_fault) begin
      ls_fault   <= 1'b1;
      fault_addr <= ls_addr;
    end else begin
      ls_fault   <= ls_fault;
      fault_addr <= fault_addr;
    end
  end

  // Next state and memory-side outputs; everything is held quiet in reset.
  always_comb begin
    state_next  = state;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    ls_stall    = 1'b0;
    ls_rdata    = '0;
    write_data  = '0;
    mem_address = word_index;
    if (!rst_n) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (ls_req && !misalign_now) begin
            case (ls_op)
              OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
                MemRead  = 1'b1;
                ls_rdata = lane_load;
              end
              OP_SW: begin
                MemWrite   = 1'b1;
                write_data = ls_wdata;
              end
              OP_SH, OP_SB: begin
                MemRead    = 1'b1;
                ls_stall   = 1'b1;
                state_next = RMW_WR;
              end
              default: begin
                MemRead  = 1'b0;
                MemWrite = 1'b0;
              end
            endcase
          end else begin
            state_next = IDLE;
          end
        end
        RMW_WR: begin
          MemWrite    = 1'b1;
          write_data  = merge_word;
          mem_address = merge_index;
          state_next  = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural word memory and
// a byte-level reference model.
module tb_load_store_unit;

  localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011,
                         LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

  logic        clk, rst_n, ls_req;
  logic [2:0]  ls_op;
  logic [31:0] ls_addr, ls_wdata, ls_rdata, fault_addr, mem_address, write_data, read_data;
  logic        ls_stall, ls_misalign, ls_fault, MemRead, MemWrite;

  logic [31:0] mem [0:15];
  logic        pre_we;
  logic [3:0]  pre_idx;
  logic [31:0] pre_val;

  logic [31:0] ref_mem [0:15];
  logic        model_fault;
  logic [31:0] model_fault_addr;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] exp;
  } load_vec_t;
  load_vec_t vecs [8];

  load_store_unit #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .ls_req(ls_req), .ls_op(ls_op), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_stall(ls_stall),
    .ls_misalign(ls_misalign), .ls_fault(ls_fault), .fault_addr(fault_addr),
    .mem_address(mem_address), .write_data(write_data), .MemRead(MemRead),
    .MemWrite(MemWrite), .read_data(read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign read_data = mem[mem_address[3:0]];
  always @(posedge clk) begin
    if (MemWrite) mem[mem_address[3:0]] <= write_data;
    else if (pre_we) mem[pre_idx] <= pre_val;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic model_misaligned(input logic [2:0] op, input logic [31:0] addr);
    int size;
    if (op == LW || op == SW) size = 4;
    else if (op == LH || op == LHU || op == SH) size = 2;
    else size = 1;
    return (int'(addr) % size) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr);
    logic [31:0] w;
    int k, h, b, hv;
    w  = ref_mem[addr[5:2]];
    k  = int'(addr[1:0]);
    h  = int'(addr[1]);
    b  = int'((w >> (8 * (3 - k))) & 32'h0000_00FF);
    hv = int'((w >> (16 * (1 - h))) & 32'h0000_FFFF);
    case (op)
      LW:  return w;
      LBU: return 32'(b);
      LHU: return 32'(hv);
      LB:  return 32'((b > 127) ? b - 256 : b);
      LH:  return 32'((hv > 32767) ? hv - 65536 : hv);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_merge(input logic [2:0] op, input logic [31:0] addr,
                                              input logic [31:0] wd);
    logic [31:0] w, mask, val;
    int sh;
    w = ref_mem[addr[5:2]];
    if (op == SB) begin
      sh = 8 * (3 - int'(addr[1:0]));
      mask = 32'h0000_00FF << sh;
      val  = (wd & 32'h0000_00FF) << sh;
    end else begin
      sh = 16 * (1 - int'(addr[1]));
      mask = 32'h0000_FFFF << sh;
      val  = (wd & 32'h0000_FFFF) << sh;
    end
    return (w & ~mask) | val;
  endfunction

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    ls_req = 1'b0; pre_we = 1'b1; pre_idx = 4'(idx); pre_val = val;
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic check_fault();
    check("ls_fault", {31'b0, ls_fault}, {31'b0, model_fault});
    check("fault_addr", fault_addr, model_fault_addr);
  endtask

  // One complete request, checked against the reference model.
  task automatic do_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    logic mis;
    logic [31:0] idx, merged;
    mis = model_misaligned(op, addr);
    idx = {2'b00, addr[31:2]};
    @(negedge clk);
    check_fault();
    ls_req = 1'b1; ls_op = op; ls_addr = addr; ls_wdata = wd;
    #2;
    check("misalign", {31'b0, ls_misalign}, {31'b0, mis});
    if (mis) begin
      check("mis_read", {31'b0, MemRead}, 32'd0);
      check("mis_write", {31'b0, MemWrite}, 32'd0);
      check("mis_rdata", ls_rdata, 32'd0);
      check("mis_stall", {31'b0, ls_stall}, 32'd0);
      if (!model_fault) begin
        model_fault = 1'b1;
        model_fault_addr = addr;
      end
    end else if (op <= LBU) begin
      check("load_rdata", ls_rdata, model_load(op, addr));
      check("load_read", {31'b0, MemRead}, 32'd1);
      check("load_stall", {31'b0, ls_stall}, 32'd0);
    end else if (op == SW) begin
      check("sw_write", {31'b0, MemWrite}, 32'd1);
      check("sw_read", {31'b0, MemRead}, 32'd0);
      check("sw_wdata", write_data, wd);
      check("sw_addr", mem_address, idx);
      ref_mem[addr[5:2]] = wd;
    end else begin
      merged = model_merge(op, addr, wd);
      check("rmw1_stall", {31'b0, ls_stall}, 32'd1);
      check("rmw1_read", {31'b0, MemRead}, 32'd1);
      check("rmw1_write", {31'b0, MemWrite}, 32'd0);
      @(negedge clk);
      #2;
      check("rmw2_write", {31'b0, MemWrite}, 32'd1);
      check("rmw2_read", {31'b0, MemRead}, 32'd0);
      check("rmw2_stall", {31'b0, ls_stall}, 32'd0);
      check("rmw2_wdata", write_data, merged);
      check("rmw2_addr", mem_address, idx);
      ref_mem[addr[5:2]] = merged;
    end
  endtask

  // Load with a literal expected result.
  task automatic load_expect(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    ls_req = 1'b1; ls_op = op; ls_addr = addr; ls_wdata = 32'h0;
    #2;
    check("vec_rdata", ls_rdata, exp);
    check("vec_read", {31'b0, MemRead}, 32'd1);
    check("vec_stall", {31'b0, ls_stall}, 32'd0);
    check("vec_misalign", {31'b0, ls_misalign}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{LB,  32'h4, 32'hFFFF_FF80};
    vecs[1] = '{LBU, 32'h4, 32'h0000_0080};
    vecs[2] = '{LH,  32'h6, 32'h0000_7F01};
    vecs[3] = '{LH,  32'h4, 32'hFFFF_80FF};
    vecs[4] = '{LW,  32'h4, 32'h80FF_7F01};
    vecs[5] = '{LHU, 32'h4, 32'h0000_80FF};
    vecs[6] = '{LB,  32'h6, 32'h0000_007F};
    vecs[7] = '{LBU, 32'h7, 32'h0000_0001};

    model_fault = 1'b0; model_fault_addr = 32'h0;
    pre_we = 1'b0; pre_idx = 4'h0; pre_val = 32'h0;
    rst_n = 1'b0; ls_req = 1'b1; ls_op = LW; ls_addr = 32'h4; ls_wdata = 32'h1234_5678;
    #3;
    check("rst_read", {31'b0, MemRead}, 32'd0);
    check("rst_write", {31'b0, MemWrite}, 32'd0);
    check("rst_stall", {31'b0, ls_stall}, 32'd0);
    check("rst_rdata", ls_rdata, 32'd0);
    check("rst_wdata", write_data, 32'd0);
    check_fault();

    for (int i = 0; i < 16; i++) begin
      preload(i, (i == 1) ? 32'h80FF_7F01 : (i == 2) ? 32'h1122_3344 : $urandom);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) load_expect(vecs[i].op, vecs[i].addr, vecs[i].exp);

    do_op(SB, 32'h9, 32'h0000_00AB);
    load_expect(LW, 32'h8, 32'h11AB_3344);

    preload(2, 32'h1122_3344);
    do_op(SH, 32'hA, 32'h0000_BEEF);
    load_expect(LW, 32'h8, 32'h1122_BEEF);

    do_op(LW, 32'h6, 32'h0);
    do_op(SH, 32'h3, 32'h0000_5555);
    @(negedge clk);
    ls_req = 1'b0;
    #2;
    check_fault();

    for (int i = 0; i < 150; i++) begin
      do_op(3'($urandom_range(0, 7)), 32'($urandom_range(0, 63)), $urandom);
    end
    for (int i = 0; i < 16; i++) do_op(LW, 32'(4 * i), 32'h0);

    preload(2, 32'h1122_3344);
    @(negedge clk);
    ls_req = 1'b1; ls_op = SB; ls_addr = 32'h8; ls_wdata = 32'h0000_00FF;
    #2;
    check("rstrmw_stall", {31'b0, ls_stall}, 32'd1);
    @(negedge clk);
    #2;
    check("rstrmw_write_pre", {31'b0, MemWrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstrmw_write", {31'b0, MemWrite}, 32'd0);
    check("rstrmw_wdata", write_data, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; ls_req = 1'b0;
    model_fault = 1'b0; model_fault_addr = 32'h0;
    #2;
    check_fault();
    load_expect(LW, 32'h8, 32'h1122_3344);
    do_op(LB, 32'h9, 32'h0);

    @(negedge clk);
    ls_req = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
